pc_trace_monitor: RTL and testbench

Consumer-side companion to the CPU wrapper's `pc_` output; watches the 32-bit PC stream every cycle. Records each PC change into a small FIFO and serializes records as little-endian bytes over a valid/ready byte stream, for a host-link/UART bridge. Detects program halt (PC stuck, e.g. the terminal `j .` of fib) and counts cycles to halt, so runs can be checked without a waveform.

---
 rtl/pc_trace_pkg.sv | 20 ++
 rtl/pc_trace_monitor_fifo.sv | 41 ++++
 rtl/pc_trace_monitor.sv | 143 ++++++++++++++
 tb/tb_pc_trace_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_pkg.sv
// Shared types and constants for the PC trace monitor.
// Record width follows PC_TRACE_TS_EN (adds a 32-bit timestamp).
package pc_trace_pkg;

  localparam logic [31:0] HALT_MARKER = 32'hFFFF_FFFF;

`ifdef PC_TRACE_TS_EN
  localparam int REC_W = 64;
`else
  localparam int REC_W = 32;
`endif

  localparam int REC_BYTES = REC_W / 8;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

endpackage

// File: rtl/pc_trace_monitor_fifo.sv
// Synchronous FIFO for trace records.
// The caller guarantees no write when full and no read when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// PC change tracer with halt detection and LE byte-stream output.
// Define PC_TRACE_TS_EN to prefix each record with a cycle timestamp.
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_,
  input  logic        trace_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic        overflow
);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam int IW = $clog2(REC_BYTES);

  logic [31:0]      pc_q;
  logic             first_q;
  logic [SW-1:0]    stuck_q, stuck_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             halted_q;
  logic             halt_pend_q;
  logic             ovf_q;
  ser_state_e       state_q;
  logic [IW-1:0]    idx_q;
  logic [REC_W-1:0] shreg_q;
  logic [7:0]       txd_q;
  logic             txv_q;

  logic             change, same, halt_hit;
  logic             pc_push, mk_push, wr_en, pop;
  logic             full, empty;
  logic [31:0]      wr_pc;
  logic [REC_W-1:0] wr_rec, rd_rec;

  assign change   = first_q | (pc_ != pc_q);
  assign same     = ~change;
  assign halt_hit = ~halted_q & same &
                    (stuck_q == SW'(HALT_CYCLES - 1));
  assign pc_push  = change & trace_en & ~halted_q;
  // The marker bypasses trace_en and waits for room
  assign mk_push  = halt_pend_q & ~full;
  assign wr_en    = (pc_push & ~full) | mk_push;
  assign wr_pc    = mk_push ? HALT_MARKER : pc_;
`ifdef PC_TRACE_TS_EN
  assign wr_rec   = {cnt_q, wr_pc};
`else
  assign wr_rec   = wr_pc;
`endif
  assign pop      = (state_q == IDLE) & ~empty;

  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_q;
  assign overflow  = ovf_q;

  always_comb begin
    stuck_d = stuck_q;
    if (change) stuck_d = '0;
    else if (stuck_q != SW'(HALT_CYCLES))
      stuck_d = stuck_q + SW'(1);
    cnt_d = cnt_q;
    if (!halted_q && cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= '0;
      first_q     <= 1'b1;
      stuck_q     <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pc_q    <= pc_;
      first_q <= 1'b0;
      stuck_q <= stuck_d;
      cnt_q   <= cnt_d;
      if (halt_hit) halted_q <= 1'b1;
      if (pc_push & full) ovf_q <= 1'b1;
      if (halt_hit) halt_pend_q <= 1'b1;
      else if (mk_push) halt_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            txd_q   <= rd_rec[7:0];
            shreg_q <= rd_rec >> 8;
            txv_q   <= 1'b1;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_q == IW'(REC_BYTES - 1)) begin
              txv_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              txd_q   <= shreg_q[7:0];
              shreg_q <= shreg_q >> 8;
            end
          end
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_rec),
    .rd_en_i  (pop),
    .rd_data_o(rd_rec),
    .full_o   (full),
    .empty_o  (empty)
  );

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Randomized bench for pc_trace_monitor against a queue-level model.
// Default build only (32-bit records).
module tb_pc_trace_monitor;
  localparam int DEPTH = 16;
  localparam int HC    = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_ = '0;
  logic        trace_en = 1'b1;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic        overflow;

  always #5 clk = ~clk;

  pc_trace_monitor #(
    .DEPTH(DEPTH),
    .HALT_CYCLES(HC)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .pc_      (pc_),
    .trace_en (trace_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halted   (halted),
    .cycle_cnt(cycle_cnt),
    .overflow (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_fifo[$];
  logic [31:0] m_cur;
  int          m_idx;
  bit          m_busy;
  logic [31:0] m_prev;
  bit          m_first, m_halted, m_pend, m_ovf;
  int          m_run;
  logic [31:0] m_cyc;
  logic [7:0]  cap[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_fifo.delete();
    m_cur = '0; m_idx = 0; m_busy = 0;
    m_prev = '0; m_first = 1; m_halted = 0;
    m_pend = 0; m_ovf = 0; m_run = 0; m_cyc = '0;
  endfunction

  // One clock edge of the reference behaviour
  function automatic void m_step();
    bit chg, hit, full_pre;
    chg = m_first || (pc_ != m_prev);
    hit = 0;
    if (chg) m_run = 0;
    else begin
      m_run++;
      if (!m_halted && m_run == HC) hit = 1;
    end
    full_pre = (m_fifo.size() == DEPTH);
    if (m_busy) begin
      if (tx_ready) begin
        m_idx++;
        if (m_idx == 4) m_busy = 0;
      end
    end else if (m_fifo.size() > 0) begin
      m_cur = m_fifo.pop_front();
      m_idx = 0;
      m_busy = 1;
    end
    if (!m_halted && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (chg && trace_en && !m_halted) begin
      if (full_pre) m_ovf = 1;
      else m_fifo.push_back(pc_);
    end
    if (m_pend && !full_pre) begin
      m_fifo.push_back(32'hFFFF_FFFF);
      m_pend = 0;
    end
    if (hit) begin
      m_halted = 1;
      m_pend = 1;
    end
    m_prev = pc_;
    m_first = 0;
  endfunction

  task automatic check_out();
    chk("tx_valid", tx_valid, m_busy);
    if (m_busy) chk("tx_data", tx_data, m_cur[8*m_idx +: 8]);
    chk("halted", halted, m_halted);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cycle(input logic [31:0] p, input logic te,
                       input logic rdy);
    pc_ = p; trace_en = te; tx_ready = rdy;
    if (tx_valid && tx_ready) cap.push_back(tx_data);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_out();
  endtask

  task automatic rst_checks();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    rst_checks();
    m_reset();
    cap.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_word(input string tag, input int base,
                          input logic [31:0] exp);
    logic [31:0] w;
    w = '0;
    if (cap.size() >= base + 4)
      w = {cap[base+3], cap[base+2], cap[base+1], cap[base]};
    chk(tag, w, exp);
  endtask

  initial begin
    logic [31:0] p;
    bit hit2;
    @(negedge clk);
    do_reset();

    // Directed: 0,4,8
    cycle(32'h0, 1, 1);
    cycle(32'h4, 1, 1);
    cycle(32'h8, 1, 1);
    for (int i = 0; i < 22; i++) cycle(32'h8, 1, 1);
    chk_word("seq_rec0", 0, 32'h0);
    chk_word("seq_rec1", 4, 32'h4);
    chk_word("seq_rec2", 8, 32'h8);
    chk("seq_ovf", overflow, 0);

    // Halt on stuck PC
    do_reset();
    cycle(32'h3C, 1, 1);
    for (int i = 0; i < 30; i++) cycle(32'h40, 1, 1);
    chk("halt_len", cap.size(), 12);
    chk_word("halt_rec0", 0, 32'h3C);
    chk_word("halt_rec1", 4, 32'h40);
    chk_word("halt_marker", 8, 32'hFFFF_FFFF);
    chk("halt_cnt", cycle_cnt, 32'd10);

    // Overflow with sink stalled, then release
    do_reset();
    for (int i = 0; i < 20; i++) cycle(32'h100 + 4*i, 1, 0);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 140; i++) cycle(32'h100 + 4*19, 1, 1);
    for (int i = 0; i < 16; i++)
      chk_word("ovf_rec", 4*i, 32'h100 + 4*i);

    // Halt while FIFO full
    do_reset();
    for (int i = 0; i < 20; i++) cycle(32'h200 + 4*i, 1, 0);
    for (int i = 0; i < 15; i++) cycle(32'h200 + 4*19, 1, 0);
    chk("full_halted", halted, 1);
    for (int i = 0; i < 150; i++) cycle(32'h200 + 4*19, 1, 1);
    chk_word("full_marker", cap.size() - 4, 32'hFFFF_FFFF);

    // Ready toggling mid-record
    do_reset();
    for (int i = 0; i < 60; i++)
      cycle(32'h300 + 4*(i/3), 1, logic'(i % 2));

    // Reset during byte 2 of a record
    do_reset();
    hit2 = 0;
    for (int i = 0; i < 40 && !hit2; i++) begin
      cycle(32'h400 + 4*i, 1, logic'(i % 2));
      if (m_busy && m_idx == 2) hit2 = 1;
    end
    chk("reach_byte2", hit2, 1);
    p = pc_;
    #2;
    rstn = 1'b0;
    #1;
    rst_checks();
    m_reset();
    cap.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) cycle(p, 1, 1);
    chk_word("post_rst_rec", 0, p);

    // Random episodes
    for (int e = 0; e < 6; e++) begin
      do_reset();
      p = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, (e % 2) ? 15 : 3) == 0)
          p = $urandom & 32'hFFFF_FFFC;
        cycle(p, logic'($urandom_range(0, 9) != 0),
              logic'($urandom_range(0, 3) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
